// File: rtl/salsa_pipe_mt_if.sv
// salsa_pipe_mt_if: job/result bundle for salsa_pipe_mt.
//   master drives in_valid/in_tag/in_b/in_bx and watches in_ready and all results.
//   slave (the engine) drives in_ready, out_valid, out_tag, out_data, addr_valid,
//   out_addr and inflight.
interface salsa_pipe_mt_if #(
  parameter int TAG_W  = 3,
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [511:0]      in_b;
  logic [511:0]      in_bx;
  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [511:0]      out_data;
  logic              addr_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [3:0]        inflight;
  modport master (
    output in_valid, in_tag, in_b, in_bx,
    input  in_ready, out_valid, out_tag, out_data, addr_valid, out_addr, inflight
  );
  modport slave (
    input  in_valid, in_tag, in_b, in_bx,
    output in_ready, out_valid, out_tag, out_data, addr_valid, out_addr, inflight
  );
endinterface

// File: rtl/salsa_pipe_mt.sv
// salsa_pipe_mt: multi-threaded Salsa20/(2*DOUBLE_ROUNDS) block engine with feedforward.
//   clk, rst_n (async, active-low) plain ports; job/result signals via salsa_pipe_mt_if.slave:
//   in_valid/in_ready/in_tag/in_b/in_bx accept a job, out_valid/out_tag/out_data return
//   Salsa(B^Bx)+(B^Bx), addr_valid/out_addr give word0[ADDR_W-1:0], inflight counts open jobs.
//   Macro SALSA_EARLY_ADDR_EN: addr_valid/out_addr lead out_valid by one cycle.
module salsa_pipe_mt #(
  parameter int DOUBLE_ROUNDS = 4,
  parameter int TAG_W         = 3,
  parameter int ADDR_W        = 10
) (
  input logic clk,
  input logic rst_n,
  salsa_pipe_mt_if.slave bus
);
  localparam int SLOTS = 1 << TAG_W;
  localparam logic [3:0] LAST = 4'(DOUBLE_ROUNDS - 1);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Word index of position j in quarter q: columns for steps 0-3, rows for 4-7.
  function automatic int idx(input int st, input int q, input int j);
    return st < 4 ? (5 * q + 4 * j) % 16 : 4 * q + (q + j) % 4;
  endfunction

  // One scrypt step: in every quarter, y[k+1] ^= rotl(y[k] + y[k-1], r). The four
  // quarters touch disjoint words, so all operands come from the unmodified input.
  function automatic logic [511:0] step(input logic [511:0] s, input int st);
    logic [511:0] r;
    int k, ya, yb, yt, rt;
    r  = s;
    k  = st % 4;
    rt = k == 0 ? 7 : k == 1 ? 9 : k == 2 ? 13 : 18;
    for (int q = 0; q < 4; q++) begin
      yt = idx(st, q, (k + 1) % 4);
      ya = idx(st, q, k);
      yb = idx(st, q, (k + 3) % 4);
      r[32*yt +: 32] = s[32*yt +: 32] ^ rotl(s[32*ya +: 32] + s[32*yb +: 32], rt);
    end
    return r;
  endfunction

  logic [511:0]     st [8];
  logic [511:0]     nx [8];
  logic [TAG_W-1:0] tag [8];
  logic [3:0]       rnd [8];
  logic [7:0]       v;
  logic [511:0]     ff [SLOTS];
  logic [SLOTS-1:0] busy;
  logic [3:0]       inflight;
  logic [511:0]     xx, ffr, res;
  logic             recirc, fin, accept, ready;

  assign xx           = bus.in_b ^ bus.in_bx;
  assign recirc       = v[7] && rnd[7] < LAST;
  assign fin          = v[7] && rnd[7] == LAST;
  assign ready        = !recirc && !busy[bus.in_tag] && inflight < 4'd8;
  assign accept       = bus.in_valid && ready;
  assign ffr          = ff[tag[7]];
  assign bus.in_ready = ready;
  assign bus.inflight = inflight;

  always_comb begin
    res   = '0;
    nx[0] = step(recirc ? st[7] : xx, 0);
    for (int i = 1; i < 8; i++) nx[i] = step(st[i-1], i);
    for (int i = 0; i < 16; i++) res[32*i +: 32] = st[7][32*i +: 32] + ffr[32*i +: 32];
  end

  // Datapath and feedforward store need no reset: stage valids gate every use.
  always_ff @(posedge clk) begin
    st[0]  <= nx[0];
    tag[0] <= recirc ? tag[7] : bus.in_tag;
    rnd[0] <= recirc ? rnd[7] + 4'd1 : 4'd0;
    for (int i = 1; i < 8; i++) begin
      st[i]  <= nx[i];
      tag[i] <= tag[i-1];
      rnd[i] <= rnd[i-1];
    end
    if (accept) ff[bus.in_tag] <= xx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v              <= '0;
      busy           <= '0;
      inflight       <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_tag    <= '0;
      bus.out_data   <= '0;
      bus.addr_valid <= 1'b0;
      bus.out_addr   <= '0;
    end else begin
      v             <= {v[6:0], recirc || accept};
      inflight      <= inflight + 4'(accept) - 4'(fin);
      if (fin) busy[tag[7]] <= 1'b0;
      if (accept) busy[bus.in_tag] <= 1'b1;
      bus.out_valid <= fin;
      if (fin) begin
        bus.out_data <= res;
        bus.out_tag  <= tag[7];
      end
`ifdef SALSA_EARLY_ADDR_EN
      // Final token entering stage 7: its word0 plus feedforward gives the address now.
      bus.addr_valid <= v[6] && rnd[6] == LAST;
      if (v[6] && rnd[6] == LAST) bus.out_addr <= ADDR_W'(nx[7][31:0] + ff[tag[6]][31:0]);
`else
      bus.addr_valid <= fin;
      if (fin) bus.out_addr <= res[ADDR_W-1:0];
`endif
    end
  end
endmodule

// File: tb/tb_salsa_pipe_mt.sv
// tb_salsa_pipe_mt: directed checks of salsa_pipe_mt against an RFC vector and a reference model.
module tb_salsa_pipe_mt;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef SALSA_EARLY_ADDR_EN
  localparam int LEAD = 1;
`else
  localparam int LEAD = 0;
`endif

  localparam logic [511:0] RFC_IN = {
    32'h5ec2b8b8, 32'h8dc6ebed, 32'h2948c709, 32'h291d0276,
    32'h32aac55a, 32'h4b1e1214, 32'h853d9bdf, 32'h19f324ee,
    32'h1d3bcd6d, 32'h1146f80d, 32'hb5c1618c, 32'h5b55eeba,
    32'h268f7141, 32'he640a97c, 32'h86c93e4f, 32'h219a877e};
  localparam logic [511:0] RFC_OUT = {
    32'h818f61c7, 32'h3d67ad24, 32'h5c74912c, 32'h10cc24e4,
    32'hba966da0, 32'hb7c56bfe, 32'hbce6c9e3, 32'h683139b4,
    32'h292f6896, 32'h631c7bfd, 32'h7d33fda2, 32'h81214b04,
    32'h05ef0c02, 32'hcbca813b, 32'h99cc0866, 32'h9c851fa4};

  salsa_pipe_mt_if #(.TAG_W(3), .ADDR_W(10)) bus ();
  salsa_pipe_mt_if #(.TAG_W(3), .ADDR_W(10)) bus1 ();

  salsa_pipe_mt #(.DOUBLE_ROUNDS(4), .TAG_W(3), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  salsa_pipe_mt #(.DOUBLE_ROUNDS(1), .TAG_W(3), .ADDR_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference Salsa20 written quarter-round by quarter-round, RFC style.
  logic [31:0] mx [16];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic void qr(input int a, input int b, input int c, input int d);
    mx[b] = mx[b] ^ rotl(mx[a] + mx[d], 7);
    mx[c] = mx[c] ^ rotl(mx[b] + mx[a], 9);
    mx[d] = mx[d] ^ rotl(mx[c] + mx[b], 13);
    mx[a] = mx[a] ^ rotl(mx[d] + mx[c], 18);
  endfunction

  function automatic logic [511:0] model(input logic [511:0] b, input logic [511:0] bx, input int dr);
    logic [511:0] x, r;
    x = b ^ bx;
    for (int i = 0; i < 16; i++) mx[i] = x[32*i +: 32];
    for (int n = 0; n < dr; n++) begin
      qr(0, 4, 8, 12);  qr(5, 9, 13, 1);  qr(10, 14, 2, 6);  qr(15, 3, 7, 11);
      qr(0, 1, 2, 3);   qr(5, 6, 7, 4);   qr(10, 11, 8, 9);  qr(15, 12, 13, 14);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = mx[i] + x[32*i +: 32];
    return r;
  endfunction

  function automatic logic [511:0] pat(input int j, input int salt);
    logic [511:0] r;
    for (int i = 0; i < 16; i++)
      r[32*i +: 32] = (32'(j * 16 + i + 1) * 32'h9e3779b9) ^ (32'(salt) * 32'h01000193);
    return r;
  endfunction

  int m_cyc [$];
  logic [2:0] m_tag [$];
  logic [511:0] m_data [$];
  int a_cyc [$];
  logic [9:0] a_addr [$];
  int e_cyc [$];
  logic [2:0] e_tag [$];
  logic [511:0] e_data [$];

  always @(negedge clk) begin
    if (bus.out_valid) begin
      m_cyc.push_back(cyc);
      m_tag.push_back(bus.out_tag);
      m_data.push_back(bus.out_data);
    end
    if (bus.addr_valid) begin
      a_cyc.push_back(cyc);
      a_addr.push_back(bus.out_addr);
    end
  end

  // Called at a falling edge; holds the offer until accepted or lim cycles pass.
  task automatic send(input logic [2:0] t, input logic [511:0] b, input logic [511:0] bx,
                      input int lim, output int acc);
    acc = -1;
    bus.in_valid = 1'b1;
    bus.in_tag   = t;
    bus.in_b     = b;
    bus.in_bx    = bx;
    for (int i = 0; i < lim; i++) begin
      #1;
      if (bus.in_ready) begin
        acc = cyc;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_job(input logic [2:0] t, input logic [511:0] b, input logic [511:0] bx,
                            input int acc);
    e_tag.push_back(t);
    e_data.push_back(model(b, bx, 4));
    e_cyc.push_back(acc + 33);
  endtask

  task automatic rst_checks(input string p);
    check({p, "_out_valid"},  512'(bus.out_valid), 512'(0));
    check({p, "_addr_valid"}, 512'(bus.addr_valid), 512'(0));
    check({p, "_out_data"},   bus.out_data, 512'(0));
    check({p, "_out_tag"},    512'(bus.out_tag), 512'(0));
    check({p, "_out_addr"},   512'(bus.out_addr), 512'(0));
    check({p, "_inflight"},   512'(bus.inflight), 512'(0));
    check({p, "_in_ready"},   512'(bus.in_ready), 512'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, a0, at2, n;
    logic [511:0] exp1;
    bus.in_valid = 1'b0;  bus.in_tag = '0;  bus.in_b = '0;  bus.in_bx = '0;
    bus1.in_valid = 1'b0; bus1.in_tag = '0; bus1.in_b = '0; bus1.in_bx = '0;
    repeat (2) @(negedge clk);
    #1 rst_checks("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    // RFC 7914 Salsa20/8 vector
    send(3'd5, RFC_IN, 512'(0), 10, acc);
    expect_job(3'd5, RFC_IN, 512'(0), acc);
    check("rfc_inflight_busy", 512'(bus.inflight), 512'(1));
    repeat (34) @(negedge clk);
    check("rfc_inflight_done", 512'(bus.inflight), 512'(0));
    // eight back-to-back jobs, then a ninth that must wait for the first output
    a0 = 0;
    for (int j = 0; j < 8; j++) begin
      send(3'(j), pat(j, 1), pat(j, 2), 1, acc);
      if (j == 0) a0 = acc;
      check($sformatf("b2b_accept%0d", j), 512'(acc - a0), 512'(j));
      expect_job(3'(j), pat(j, 1), pat(j, 2), acc);
    end
    send(3'd0, pat(8, 1), pat(8, 2), 60, acc);
    check("full_stall_accept", 512'(acc - a0), 512'(33));
    expect_job(3'd0, pat(8, 1), pat(8, 2), acc);
    // tag 2 is still busy; accepted only in its out_valid cycle
    send(3'd2, pat(9, 1), pat(9, 2), 60, at2);
    check("tag_reuse_accept", 512'(at2 - a0), 512'(35));
    expect_job(3'd2, pat(9, 1), pat(9, 2), at2);
    repeat (40) @(negedge clk);
    // single double round engine
    bus1.in_valid = 1'b1; bus1.in_tag = 3'd3; bus1.in_b = pat(10, 1); bus1.in_bx = pat(10, 2);
    #1 check("dr1_ready", 512'(bus1.in_ready), 512'(1));
    @(negedge clk) bus1.in_valid = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus1.out_valid) begin
        n = k;
        break;
      end
      @(negedge clk);
    end
    exp1 = model(pat(10, 1), pat(10, 2), 1);
    check("dr1_latency", 512'(n), 512'(9));
    check("dr1_data", bus1.out_data, exp1);
    check("dr1_tag", 512'(bus1.out_tag), 512'(3));
    check("dr1_addr", 512'(bus1.out_addr), 512'(exp1[9:0]));
    // reset in the middle of a job discards it
    @(negedge clk);
    send(3'd4, pat(11, 1), pat(11, 2), 10, acc);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1 rst_checks("midrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (45) @(negedge clk);
    #1 check("midrst_no_output", 512'(m_cyc.size()), 512'(e_cyc.size()));
    @(negedge clk);
    send(3'd4, pat(12, 1), pat(12, 2), 10, acc);
    check("post_rst_accept", 512'(acc >= 0), 512'(1));
    expect_job(3'd4, pat(12, 1), pat(12, 2), acc);
    repeat (40) @(negedge clk);
    #1;
    check("out_count", 512'(m_cyc.size()), 512'(e_cyc.size()));
    check("addr_count", 512'(a_cyc.size()), 512'(e_cyc.size()));
    if (m_cyc.size() > 0) begin
      check("rfc_data", m_data[0], RFC_OUT);
      check("rfc_latency", 512'(m_cyc[0] - (e_cyc[0] - 33)), 512'(33));
    end
    if (a_cyc.size() > 0) check("rfc_addr", 512'(a_addr[0]), 512'(10'h3a4));
    for (int i = 0; i < e_cyc.size(); i++) begin
      if (i < m_cyc.size()) begin
        check($sformatf("job%0d_cycle", i), 512'(m_cyc[i]), 512'(e_cyc[i]));
        check($sformatf("job%0d_tag", i), 512'(m_tag[i]), 512'(e_tag[i]));
        check($sformatf("job%0d_data", i), m_data[i], e_data[i]);
      end
      if (i < a_cyc.size()) begin
        check($sformatf("job%0d_addr_cycle", i), 512'(a_cyc[i]), 512'(e_cyc[i] - LEAD));
        check($sformatf("job%0d_addr", i), 512'(a_addr[i]), 512'(e_data[i][9:0]));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
